// File: rtl/bd8_pkg.sv
// ============================================================================
//  Module      : bd8_pkg
//  Description : Shared types for the BubbleDrive8 mode supervisor: FSM state
//                encodings, LED drive modes, the block-enable vector and small
//                decode helpers used by bd8_mode_supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bd8_pkg;

    // Encodings are visible on the STATE debug port; keep them stable.
    typedef enum logic [2:0] {
        ST_RESET    = 3'b000,
        ST_MODE_SEL = 3'b001,
        ST_EMU      = 3'b010,
        ST_MPSSE    = 3'b101,
        ST_ERR_BRD  = 3'b110,
        ST_ERR_USB  = 3'b111
    } state_e;

    typedef enum logic [1:0] {
        LED_OFF  = 2'd0,
        LED_ON   = 2'd1,
        LED_SLOW = 2'd2,
        LED_FAST = 2'd3
    } led_mode_e;

    // Every field is an active-low enable.
    typedef struct packed {
        logic emu;
        logic temp;
        logic fifo;
        logic mpsse;
    } en_vec_t;

    localparam en_vec_t c_en_all_off = '{emu: 1'b1, temp: 1'b1, fifo: 1'b1, mpsse: 1'b1};

    function automatic en_vec_t en_for_state(input state_e s);
        en_vec_t en;
        en = c_en_all_off;
        case (s)
            ST_EMU:   en = '{emu: 1'b0, temp: 1'b0, fifo: 1'b0, mpsse: 1'b1};
            ST_MPSSE: en = '{emu: 1'b1, temp: 1'b1, fifo: 1'b1, mpsse: 1'b0};
            default:  en = c_en_all_off;
        endcase
        return en;
    endfunction

    // Active-low LED level for a mode; blinking modes follow the blinker
    // phase, where phase 1 means the LED is dark.
    function automatic logic led_level(input led_mode_e m, input logic phase);
        logic lvl;
        case (m)
            LED_ON:               lvl = 1'b0;
            LED_SLOW, LED_FAST:   lvl = phase;
            default:              lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bd8_debounce.sv
// ============================================================================
//  Module      : bd8_debounce
//  Description : Single-bit debouncer. A candidate register follows the raw
//                input; once the raw input has matched the candidate for
//                DEBOUNCE_CYC consecutive cycles the candidate is copied to
//                the output on the following edge.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                i_raw  - raw (possibly bouncing) input
//                o_deb  - debounced output, resets to RESET_VAL
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bd8_debounce #(
    parameter int   DEBOUNCE_CYC = 4800,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb
);

    localparam int c_cnt_w = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= RESET_VAL;
            r_cnt  <= '0;
            r_deb  <= RESET_VAL;
        end else if (i_raw != r_cand) begin
            r_cand <= i_raw;
            r_cnt  <= '0;
        end else if (r_cnt == c_cnt_last) begin
            // Counter parks at its terminal value while the input is stable.
            r_deb  <= r_cand;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_deb = r_deb;

endmodule

`default_nettype wire

// File: rtl/bd8_mode_supervisor.sv
// ============================================================================
//  Module      : bd8_mode_supervisor
//  Description : Power/mode supervisor for BubbleDrive8. Debounces board
//                power (MRST) and USB power (PWRSTAT), selects emulator,
//                MPSSE-standby or an error mode, drives the active-low block
//                enables and the status LEDs through a two-rate blinker.
//  Ports       : MCLK          - system clock
//                nRESET        - asynchronous active-low reset
//                PWRSTAT       - raw power-mux status (1 = USB)
//                MRST          - raw PCB power status (0 = board power OK)
//                nTEMPLO       - low-temperature flag, forces FIFO enable
//                nDELAYING     - tempsense delay indicator
//                nEMU_EN/nTEMP_EN/nFIFO_EN/nMPSSE_EN - active-low enables
//                nLED_PWROK/nLED_STANDBY/nLED_DELAYING - active-low LEDs
//                STATE         - current FSM state (debug)
//  Build macro : BD8_ERROR_LATCH_EN - when defined, ERR_BRD and ERR_USB are
//                left only through nRESET.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bd8_mode_supervisor
    import bd8_pkg::*;
#(
    parameter int CLK_HZ       = 48000000,
    parameter int BLINK_HZ     = 1,
    parameter int FAST_DIV     = 4,
    parameter int DEBOUNCE_CYC = 4800,
    parameter int SETTLE_CYC   = 48000
) (
    input  logic       MCLK,
    input  logic       nRESET,
    input  logic       PWRSTAT,
    input  logic       MRST,
    input  logic       nTEMPLO,
    input  logic       nDELAYING,
    output logic       nEMU_EN,
    output logic       nTEMP_EN,
    output logic       nFIFO_EN,
    output logic       nMPSSE_EN,
    output logic       nLED_PWROK,
    output logic       nLED_STANDBY,
    output logic       nLED_DELAYING,
    output logic [2:0] STATE
);

    localparam int c_half      = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_fast_raw  = c_half / FAST_DIV;
    localparam int c_fast_half = (c_fast_raw > 0) ? c_fast_raw : 1;
    localparam int c_blink_w   = (c_half > 1) ? $clog2(c_half) : 1;
    localparam int c_settle_w  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [c_blink_w-1:0]  c_half_last   = c_blink_w'(c_half - 1);
    localparam logic [c_blink_w-1:0]  c_fast_last   = c_blink_w'(c_fast_half - 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYC - 1);

    // ------------------------------------------------------------------
    // Input debouncing; reset values model "board power absent, no USB".
    // ------------------------------------------------------------------
    logic       w_deb_m;
    logic       w_deb_p;
    logic [1:0] w_pm;

    bd8_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_VAL    (1'b1)
    ) u_deb_mrst (
        .clk   (MCLK),
        .rst_n (nRESET),
        .i_raw (MRST),
        .o_deb (w_deb_m)
    );

    bd8_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_VAL    (1'b0)
    ) u_deb_pwr (
        .clk   (MCLK),
        .rst_n (nRESET),
        .i_raw (PWRSTAT),
        .o_deb (w_deb_p)
    );

    assign w_pm = {w_deb_p, w_deb_m};

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    state_e                r_state;
    state_e                w_state_nxt;
    logic [1:0]            r_pm_prev;
    logic [c_settle_w-1:0] r_settle_cnt;

    en_vec_t   w_en;
    led_mode_e w_pwrok_mode;
    led_mode_e w_stby_mode;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= ST_RESET;
            r_pm_prev    <= 2'b01;
            r_settle_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pm_prev <= w_pm;
            // The settle count only runs in MODE_SEL and restarts whenever
            // the debounced pair moves, so a decision always sees a quiet
            // SETTLE_CYC window.
            if ((r_state != ST_MODE_SEL) || (w_pm != r_pm_prev)) begin
                r_settle_cnt <= '0;
            end else if (r_settle_cnt != c_settle_last) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_en         = en_for_state(r_state);
        w_pwrok_mode = LED_OFF;
        w_stby_mode  = LED_OFF;

        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_MODE_SEL;
            end
            ST_MODE_SEL: begin
                // Decision uses the live pair; if it moved this very cycle
                // the target state re-evaluates and bounces back to RESET.
                if (r_settle_cnt == c_settle_last) begin
                    case (w_pm)
                        2'b00:   w_state_nxt = ST_EMU;
                        2'b01:   w_state_nxt = ST_ERR_BRD;
                        2'b10:   w_state_nxt = ST_ERR_USB;
                        default: w_state_nxt = ST_MPSSE;
                    endcase
                end
            end
            ST_EMU: begin
                w_pwrok_mode = LED_ON;
                if (w_deb_m) begin
                    w_state_nxt = ST_RESET;
                end
            end
            ST_MPSSE: begin
                w_pwrok_mode = LED_ON;
                w_stby_mode  = LED_SLOW;
                if (w_pm != 2'b11) begin
                    w_state_nxt = ST_RESET;
                end
            end
`ifdef BD8_ERROR_LATCH_EN
            ST_ERR_BRD: begin
                w_pwrok_mode = LED_SLOW;
            end
            ST_ERR_USB: begin
                w_pwrok_mode = LED_FAST;
            end
`else
            ST_ERR_BRD: begin
                w_pwrok_mode = LED_SLOW;
                if (!w_deb_m) begin
                    w_state_nxt = ST_RESET;
                end
            end
            ST_ERR_USB: begin
                w_pwrok_mode = LED_FAST;
                if (w_pm != 2'b10) begin
                    w_state_nxt = ST_RESET;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase

        // Low temperature needs the FIFO heater path regardless of mode.
        if (!nTEMPLO) begin
            w_en.fifo = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Blinker: one counter shared by both blinking LEDs. It is held at
    // zero/dark whenever nothing blinks, and restarted on any LED-mode
    // change, so each blink sequence opens with a full dark half-period.
    // ------------------------------------------------------------------
    logic [3:0]           r_modes_prev;
    logic [3:0]           w_modes;
    logic                 w_blinking;
    logic                 w_fast;
    logic [c_blink_w-1:0] w_blink_last;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase;

    assign w_modes      = {w_pwrok_mode, w_stby_mode};
    assign w_fast       = (w_pwrok_mode == LED_FAST) || (w_stby_mode == LED_FAST);
    assign w_blinking   = w_fast || (w_pwrok_mode == LED_SLOW) || (w_stby_mode == LED_SLOW);
    assign w_blink_last = w_fast ? c_fast_last : c_half_last;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_modes_prev <= {LED_OFF, LED_OFF};
            r_blink_cnt  <= '0;
            r_phase      <= 1'b1;
        end else begin
            r_modes_prev <= w_modes;
            if ((w_modes != r_modes_prev) || !w_blinking) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else if (r_blink_cnt == w_blink_last) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    en_vec_t r_en;
    logic    r_led_pwrok;
    logic    r_led_stby;
    logic    r_led_dly;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_en        <= c_en_all_off;
            r_led_pwrok <= 1'b1;
            r_led_stby  <= 1'b1;
            r_led_dly   <= 1'b1;
        end else begin
            r_en        <= w_en;
            r_led_pwrok <= led_level(w_pwrok_mode, r_phase);
            r_led_stby  <= led_level(w_stby_mode, r_phase) & nDELAYING;
            r_led_dly   <= (r_state == ST_EMU) ? nDELAYING : 1'b1;
        end
    end

    assign nEMU_EN       = r_en.emu;
    assign nTEMP_EN      = r_en.temp;
    assign nFIFO_EN      = r_en.fifo;
    assign nMPSSE_EN     = r_en.mpsse;
    assign nLED_PWROK    = r_led_pwrok;
    assign nLED_STANDBY  = r_led_stby;
    assign nLED_DELAYING = r_led_dly;
    assign STATE         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_bd8_mode_supervisor.sv
// ============================================================================
//  Module      : tb_bd8_mode_supervisor
//  Description : Directed bench for bd8_mode_supervisor with small timing
//                parameters (HALF=10, FAST_HALF=5, DEBOUNCE_CYC=4,
//                SETTLE_CYC=8). Expected state transitions and timed output
//                snapshots are queued by the stimulus and checked by an
//                independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bd8_mode_supervisor;

    logic MCLK      = 1'b0;
    logic nRESET    = 1'b1;
    logic PWRSTAT   = 1'b0;
    logic MRST      = 1'b0;
    logic nTEMPLO   = 1'b1;
    logic nDELAYING = 1'b1;

    logic       nEMU_EN, nTEMP_EN, nFIFO_EN, nMPSSE_EN;
    logic       nLED_PWROK, nLED_STANDBY, nLED_DELAYING;
    logic [2:0] STATE;

    bd8_mode_supervisor #(
        .CLK_HZ       (1000),
        .BLINK_HZ     (50),
        .FAST_DIV     (2),
        .DEBOUNCE_CYC (4),
        .SETTLE_CYC   (8)
    ) dut (
        .MCLK          (MCLK),
        .nRESET        (nRESET),
        .PWRSTAT       (PWRSTAT),
        .MRST          (MRST),
        .nTEMPLO       (nTEMPLO),
        .nDELAYING     (nDELAYING),
        .nEMU_EN       (nEMU_EN),
        .nTEMP_EN      (nTEMP_EN),
        .nFIFO_EN      (nFIFO_EN),
        .nMPSSE_EN     (nMPSSE_EN),
        .nLED_PWROK    (nLED_PWROK),
        .nLED_STANDBY  (nLED_STANDBY),
        .nLED_DELAYING (nLED_DELAYING),
        .STATE         (STATE)
    );

    always #5 MCLK = ~MCLK;

    int cyc = 0;
    always @(posedge MCLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Observation vector: {STATE, nEMU, nTEMP, nFIFO, nMPSSE, PWROK, STBY, DLY}
    localparam logic [9:0] M_ALL = 10'b111_1111_111;
    localparam logic [9:0] M_ST  = 10'b111_0000_000;
    localparam logic [9:0] M_EN  = 10'b000_1111_000;
    localparam logic [9:0] M_PW  = 10'b000_0000_100;
    localparam logic [9:0] M_SB  = 10'b000_0000_010;
    localparam logic [9:0] M_DL  = 10'b000_0000_001;
    localparam logic [9:0] M_FI  = 10'b000_0010_000;
    localparam logic [9:0] M_MP  = 10'b000_0001_000;

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] exp;
        logic [9:0] mask;
    } chk_t;

    chk_t       chk_q[$];
    logic [2:0] st_q[$];

    logic [9:0] obs;
    assign obs = {STATE, nEMU_EN, nTEMP_EN, nFIFO_EN, nMPSSE_EN, nLED_PWROK, nLED_STANDBY, nLED_DELAYING};

    function automatic logic [9:0] vec(input logic [2:0] s, input logic [3:0] en,
                                       input logic pw, input logic sb, input logic dl);
        return {s, en, pw, sb, dl};
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [9:0] e, input logic [9:0] m);
        chk_t k;
        k.cyc  = c;
        k.name = nm;
        k.exp  = e;
        k.mask = m;
        chk_q.push_back(k);
    endtask

    // Monitor: state-change scoreboard plus timed output snapshots.
    initial begin
        logic [2:0] last_st;
        chk_t       k;
        logic [2:0] want;
        last_st = 3'b000;
        forever begin
            @(negedge MCLK);
            if (STATE !== last_st) begin
                total++;
                if (st_q.size() == 0) begin
                    bad++;
                    $display("FAIL state_seq: got %b want no change (from %b) at cyc %0d", STATE, last_st, cyc);
                end else begin
                    want = st_q.pop_front();
                    if (STATE !== want) begin
                        bad++;
                        $display("FAIL state_seq: got %b want %b at cyc %0d", STATE, want, cyc);
                    end
                end
                last_st = STATE;
            end
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                k = chk_q.pop_front();
                total++;
                if ((obs & k.mask) !== (k.exp & k.mask)) begin
                    bad++;
                    $display("FAIL %s: got %b want %b (mask %b) at cyc %0d", k.name, obs & k.mask, k.exp & k.mask, k.mask, cyc);
                end
            end
        end
    end

    task automatic check_range(input string nm, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm, output int t);
        int n;
        n = 0;
        t = -1;
        while (STATE !== s && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        if (STATE === s) begin
            t = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got state %b want %b within %0d cycles", nm, STATE, s, budget);
        end
    endtask

    function automatic logic led_of(input int which);
        return (which == 0) ? nLED_PWROK : nLED_STANDBY;
    endfunction

    task automatic wait_led_low(input int which, input int budget, input string nm, output int t);
        int n;
        n = 0;
        t = -1;
        while (led_of(which) !== 1'b0 && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        if (led_of(which) === 1'b0) begin
            t = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got led %b want 0 within %0d cycles", nm, led_of(which), budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t0, l;

        #1 nRESET = 1'b0;
        repeat (3) @(negedge MCLK);
        expect_at(cyc, "reset_outputs", vec(3'b000, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);
        repeat (2) @(negedge MCLK);

        // {P,M}=00: RESET -> MODE_SEL -> (debounce 5 + settle 8) -> EMU
        st_q.push_back(3'b001);
        st_q.push_back(3'b010);
        nRESET = 1'b1;
        t0 = cyc;
        wait_state(3'b010, 40, "enter_emu", t);
        check_range("emu_latency", t - t0, 13, 15);
        expect_at(t + 1, "emu_outputs", vec(3'b010, 4'b0001, 1'b0, 1'b1, 1'b1), M_ALL);
        repeat (2) @(negedge MCLK);

        // nDELAYING mirrors to the DELAYING LED and forces STANDBY on
        nDELAYING = 1'b0;
        expect_at(cyc + 1, "delaying_on", vec(3'b010, 4'b0001, 1'b0, 1'b0, 1'b0), M_ALL);
        @(negedge MCLK);
        nDELAYING = 1'b1;
        expect_at(cyc + 1, "delaying_off", vec(3'b010, 4'b0001, 1'b0, 1'b1, 1'b1), M_ALL);
        @(negedge MCLK);

        // 2-cycle MRST glitch is filtered out
        MRST = 1'b1;
        repeat (2) @(negedge MCLK);
        MRST = 1'b0;
        repeat (10) @(negedge MCLK);
        expect_at(cyc + 1, "glitch_ignored", vec(3'b010, 4'b0001, 1'b0, 1'b1, 1'b1), M_ST | M_EN | M_PW);
        @(negedge MCLK);

        // Board power lost: EMU -> RESET -> MODE_SEL, enables released
        st_q.push_back(3'b000);
        st_q.push_back(3'b001);
        MRST = 1'b1;
        wait_state(3'b001, 30, "emu_exit", t);
        expect_at(t + 1, "modesel_outputs", vec(3'b001, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);

        // USB comes up before the 01 decision: {P,M}=11 -> MPSSE
        st_q.push_back(3'b101);
        PWRSTAT = 1'b1;
        wait_state(3'b101, 40, "enter_mpsse", t);
        expect_at(t + 1, "mpsse_outputs", vec(3'b101, 4'b1110, 1'b0, 1'b1, 1'b1), M_ALL);
        wait_led_low(1, 30, "stby_first_on", l);
        check_range("stby_off_first", l - t, 10, 14);
        expect_at(l + 9,  "stby_on_end",    10'b0, M_SB);
        expect_at(l + 10, "stby_off_start", M_SB,  M_SB);
        expect_at(l + 19, "stby_off_end",   M_SB,  M_SB);
        expect_at(l + 20, "stby_on_again",  10'b0, M_SB);
        repeat (21) @(negedge MCLK);

        // Low temperature forces the FIFO enable
        nTEMPLO = 1'b0;
        expect_at(cyc + 1, "templo_force", M_FI & 10'b0, M_FI | M_MP);
        @(negedge MCLK);
        nTEMPLO = 1'b1;
        expect_at(cyc + 1, "templo_release", M_FI, M_FI | M_MP);
        @(negedge MCLK);

        // {P,M}=10 -> ERR_USB, fast blink
        st_q.push_back(3'b000);
        st_q.push_back(3'b001);
        st_q.push_back(3'b111);
        MRST = 1'b0;
        wait_state(3'b111, 40, "enter_err_usb", t);
        expect_at(t + 1, "errusb_outputs", vec(3'b111, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);
        wait_led_low(0, 20, "pwrok_fast_on", l);
        check_range("fast_off_first", l - t, 5, 9);
        expect_at(l + 4,  "fast_on_end",    10'b0, M_PW);
        expect_at(l + 5,  "fast_off_start", M_PW,  M_PW);
        expect_at(l + 9,  "fast_off_end",   M_PW,  M_PW);
        expect_at(l + 10, "fast_on_again",  10'b0, M_PW);
        repeat (11) @(negedge MCLK);

`ifdef BD8_ERROR_LATCH_EN
        PWRSTAT = 1'b0;
        repeat (40) @(negedge MCLK);
        expect_at(cyc + 1, "err_usb_sticky", vec(3'b111, 4'b1111, 1'b1, 1'b1, 1'b1), M_ST | M_EN);
        @(negedge MCLK);
        wait_led_low(0, 20, "sticky_blink", l);
`else
        // Back to 00 recovers into EMU
        st_q.push_back(3'b000);
        st_q.push_back(3'b001);
        st_q.push_back(3'b010);
        PWRSTAT = 1'b0;
        wait_state(3'b010, 40, "emu_recovered", t);
        expect_at(t + 1, "emu_again_outputs", vec(3'b010, 4'b0001, 1'b0, 1'b1, 1'b1), M_ST | M_EN | M_PW);
        @(negedge MCLK);

        // {P,M}=01 -> ERR_BRD, slow blink on PWROK
        st_q.push_back(3'b000);
        st_q.push_back(3'b001);
        st_q.push_back(3'b110);
        MRST = 1'b1;
        wait_state(3'b110, 40, "enter_err_brd", t);
        expect_at(t + 1, "errbrd_outputs", vec(3'b110, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);
        wait_led_low(0, 30, "pwrok_slow_on", l);
        check_range("slow_off_first", l - t, 10, 14);
        expect_at(l + 2, "errbrd_blink_on", 10'b0, M_PW);
`endif

        // Asynchronous reset mid-blink, between clock edges
        repeat (2) @(negedge MCLK);
        @(posedge MCLK);
        #1;
        st_q.push_back(3'b000);
        expect_at(cyc, "async_reset", vec(3'b000, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);
        nRESET = 1'b0;
        repeat (3) @(negedge MCLK);
        expect_at(cyc + 1, "reset_hold", vec(3'b000, 4'b1111, 1'b1, 1'b1, 1'b1), M_ALL);
        repeat (3) @(negedge MCLK);

        total++;
        if (st_q.size() != 0 || chk_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained: got st=%0d chk=%0d want 0 0", st_q.size(), chk_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
